adder_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one WIDTH-bit add-with-carry datapath among N_REQ requesters. Each requester presents operands with a valid/ready handshake. The block grants one request per cycle, registers the sum and carry-out with the winner's ID, and holds the result until the consumer takes it. It sits in the basic-characters design between the exercise units and the single shared adder.

---
 rtl/adder_share_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/adder_share_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the round-robin adder-sharing block.
// Slot encoding and parameter defaults live here so future shared-resource blocks agree.
package adder_share_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 100;
    localparam int ID_W      = $clog2(DEF_N_REQ);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping modulo N.
// gnt is one-hot only when en is high; gnt_id reports the candidate regardless.
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = ID_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        if (en && found) gnt[gnt_id] = 1'b1;
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one WIDTH+1 bit add-with-carry among N_REQ requesters, round-robin,
// with a single registered result slot that drains and refills in the same cycle.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_cout,
    output logic [ID_W-1:0]        rsp_id
);

    slot_e            slot;
    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             cin_sel;
    logic [WIDTH:0]   sum_full;

    // Reset gates the arbiter so no ready is shown while the block is held in reset.
    assign can_accept = rst_n & ((slot == SLOT_EMPTY) | rsp_ready);

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (can_accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign rsp_valid = (slot == SLOT_FULL);

    // One-hot AND-OR operand mux keeps operands off the ready path.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                a_sel   = a_sel | req_a[i*WIDTH +: WIDTH];
                b_sel   = b_sel | req_b[i*WIDTH +: WIDTH];
                cin_sel = cin_sel | req_cin[i];
            end
        end
    end

    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel} + {{WIDTH{1'b0}}, cin_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= SLOT_EMPTY;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
            ptr      <= '0;
        end else if (accept) begin
            slot                <= SLOT_FULL;
            {rsp_cout, rsp_sum} <= sum_full;
            rsp_id              <= gnt_id;
            ptr                 <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end else if (rsp_ready) begin
            slot <= SLOT_EMPTY;
        end
    end

endmodule
